// File: rtl/frame_arbiter.sv
// frame_arbiter: grants one of two pixel sources per frame (round-robin on
// simultaneous start-of-frame), re-times the granted stream with column/row
// coordinates, discards stray beats while idle, and then inserts a fixed
// drain gap before the next grant.
module frame_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s0_data_i,
    input  logic                  s0_valid_i,
    input  logic                  s0_sof_i,
    output logic                  s0_ready_o,
    input  logic [DATA_WIDTH-1:0] s1_data_i,
    input  logic                  s1_valid_i,
    input  logic                  s1_sof_i,
    output logic                  s1_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [15:0]           col_o,
    output logic [15:0]           row_o,
    output logic                  valid_o,
    output logic                  src_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  sof_err_o,
    output logic [15:0]           drop_cnt_o
);

    localparam logic [15:0] COL_LAST   = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] ROW_LAST   = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Frame bookkeeping: coordinates of the next pixel, drain timer,
    // arbitration priority and the source owning the current frame.
    logic [15:0] col_cnt_q, col_cnt_d;
    logic [15:0] row_cnt_q, row_cnt_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        prio_q, prio_d;
    logic        active_src_q, active_src_d;

    // Registered outputs.
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic                  valid_q, valid_d;
    logic                  src_q, src_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sof_err_q, sof_err_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    // Combinational helpers.
    logic                  elig0, elig1;
    logic                  grant_any, grant_sel;
    logic                  acc, acc_src, acc_sof, beat_last;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [1:0]            discards;
    logic [16:0]           drop_sum;

    // Arbitration: a source may start a frame only with a valid sof beat;
    // on a tie the source holding priority wins.
    always_comb begin
        elig0     = s0_valid_i && s0_sof_i;
        elig1     = s1_valid_i && s1_sof_i;
        grant_any = (state_q == IDLE) && (elig0 || elig1);
        grant_sel = elig1 && (!elig0 || prio_q);
    end

    // Select the beat accepted this cycle, if any, and flag the frame's last pixel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
        acc     = 1'b0;
        acc_src = active_src_q;
        case (state_q)
            IDLE: begin
                acc     = grant_any;
                acc_src = grant_sel;
            end
            STREAM:  acc = active_src_q ? s1_valid_i : s0_valid_i;
            default: acc = 1'b0;
        endcase
        acc_data  = acc_src ? s1_data_i : s0_data_i;
        acc_sof   = acc_src ? s1_sof_i  : s0_sof_i;
        beat_last = (col_cnt_q == COL_LAST) && (row_cnt_q == ROW_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant starts a frame, last pixel enters drain, drain timer returns to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = beat_last ? DRAIN : STREAM;
            STREAM:  if (acc && beat_last) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready per state (idle discards stray beats), busy outside IDLE.
    always_comb begin
        s0_ready_o = 1'b0;
        s1_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                s0_ready_o = s0_valid_i && (!s0_sof_i || (grant_any && !grant_sel));
                s1_ready_o = s1_valid_i && (!s1_sof_i || (grant_any &&  grant_sel));
            end
            STREAM: begin
                s0_ready_o = !active_src_q;
                s1_ready_o =  active_src_q;
            end
            default: begin
                s0_ready_o = 1'b0;
                s1_ready_o = 1'b0;
            end
        endcase
        if (rst_i) begin
            s0_ready_o = 1'b0;
            s1_ready_o = 1'b0;
        end
        busy_o = (state_q != IDLE);
    end

    // Datapath next values: output re-timing, coordinate advance, counters and flags.
    always_comb begin
        data_d       = data_q;
        col_d        = col_q;
        row_d        = row_q;
        src_d        = src_q;
        valid_d      = acc;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        prio_d       = prio_q;
        active_src_d = active_src_q;
        sof_err_d    = sof_err_q;
        drop_cnt_d   = drop_cnt_q;
        frame_done_d = (state_q == DRAIN) && (drain_cnt_q == DRAIN_LAST);
        drain_cnt_d  = (state_q == DRAIN) ? drain_cnt_q + 16'd1 : 16'd0;

        discards = {1'b0, s0_valid_i && !s0_sof_i} + {1'b0, s1_valid_i && !s1_sof_i};
        drop_sum = {1'b0, drop_cnt_q} + {15'd0, discards};

        if (acc) begin
            data_d = acc_data;
            col_d  = col_cnt_q;
            row_d  = row_cnt_q;
            src_d  = acc_src;
            // Counters return to zero after the last pixel so IDLE always starts at (0,0).
            if (beat_last) begin
                col_cnt_d = 16'd0;
                row_cnt_d = 16'd0;
            end else if (col_cnt_q == COL_LAST) begin
                col_cnt_d = 16'd0;
                row_cnt_d = row_cnt_q + 16'd1;
            end else begin
                col_cnt_d = col_cnt_q + 16'd1;
            end
        end

        if (grant_any) begin
            active_src_d = grant_sel;
            prio_d       = !grant_sel;
        end

        // A second sof inside a frame is flagged but streamed through unchanged.
        if ((state_q == STREAM) && acc && acc_sof) begin
            sof_err_d = 1'b1;
        end

        if (state_q == IDLE) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Datapath registers with synchronous reset to the idle/zero state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            src_q        <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            drop_cnt_q   <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            prio_q       <= 1'b0;
            active_src_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= valid_d;
            src_q        <= src_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            drop_cnt_q   <= drop_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            prio_q       <= prio_d;
            active_src_q <= active_src_d;
        end
    end

    assign data_o       = data_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign valid_o      = valid_q;
    assign src_o        = src_q;
    assign frame_done_o = frame_done_q;
    assign sof_err_o    = sof_err_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule
